// File: rtl/microcode_sequencer.sv
// microcode_sequencer: microprogrammed controller with a registered micro-PC.
// Each microword is {seq[1:0], tgt[UADDR_W-1:0], cw[CW_W-1:0]}; seq selects
// fetch, jump, or one of two opcode dispatch tables. A stall holds the upc.
// Optional feature macro: UCODE_LOAD_EN makes the control store writable
// through ld_we/ld_addr/ld_data; without it the store is a constant ROM.
module microcode_sequencer #(
    parameter int CW_W    = 17,
    parameter int UADDR_W = 5,
    parameter int OP_W    = 7
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      stall,
    input  logic [OP_W-1:0]           op,
`ifdef UCODE_LOAD_EN
    input  logic                      ld_we,
    input  logic [UADDR_W-1:0]        ld_addr,
    input  logic [CW_W+UADDR_W+1:0]   ld_data,
`endif
    output logic [CW_W-1:0]           cw,
    output logic [UADDR_W-1:0]        upc,
    output logic                      illegal
);

    localparam int DEPTH = 2 ** UADDR_W;
    localparam int MW    = CW_W + UADDR_W + 2;

    typedef enum logic [1:0] {
        SEQ_FETCH = 2'b00,
        SEQ_JUMP  = 2'b01,
        SEQ_DISP1 = 2'b10,
        SEQ_DISP2 = 2'b11
    } seq_t;

    // Default control words, written at their native 17-bit width
    localparam logic [16:0] CW_FETCH   = 17'b10010101100000001;
    localparam logic [16:0] CW_DECODE  = 17'b00000101100001010;
    localparam logic [16:0] CW_MEMADR  = 17'b00000100010001011;
    localparam logic [16:0] CW_MEMREAD = 17'b00001000000000100;
    localparam logic [16:0] CW_MEMWB   = 17'b01000010000000000;
    localparam logic [16:0] CW_MEMWR   = 17'b00101000000000000;
    localparam logic [16:0] CW_EXER    = 17'b00000100001001000;
    localparam logic [16:0] CW_EXEI    = 17'b00000100011001000;
    localparam logic [16:0] CW_ALUWB   = 17'b01000000000000000;
    localparam logic [16:0] CW_BRANCH  = 17'b00000100010100000;

    localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0] OP_STORE  = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0] OP_RTYPE  = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0] OP_ITYPE  = OP_W'(7'b0010011);
    localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(7'b1100011);

    // Pack one microword; target wraps modulo the store depth, cw is zero-extended
    function automatic logic [MW-1:0] uword(input seq_t s, input int unsigned t,
                                            input logic [16:0] c);
        logic [UADDR_W-1:0] t_mod;
        logic [CW_W-1:0]    c_ext;
        t_mod = UADDR_W'(t);
        c_ext = CW_W'(c);
        return {s, t_mod, c_ext};
    endfunction

    // Default microprogram as a constant case table
    function automatic logic [MW-1:0] default_word(input int unsigned a);
        case (a)
            0:       return uword(SEQ_JUMP,  1, CW_FETCH);
            1:       return uword(SEQ_DISP1, 0, CW_DECODE);
            2:       return uword(SEQ_DISP2, 0, CW_MEMADR);
            3:       return uword(SEQ_JUMP,  4, CW_MEMREAD);
            4:       return uword(SEQ_FETCH, 0, CW_MEMWB);
            5:       return uword(SEQ_FETCH, 0, CW_MEMWR);
            6:       return uword(SEQ_JUMP,  8, CW_EXER);
            7:       return uword(SEQ_JUMP,  8, CW_EXEI);
            8:       return uword(SEQ_FETCH, 0, CW_ALUWB);
            9:       return uword(SEQ_FETCH, 0, CW_BRANCH);
            default: return uword(SEQ_FETCH, 0, CW_FETCH);
        endcase
    endfunction

    logic [MW-1:0]      default_tbl [DEPTH];
    logic [MW-1:0]      word;
    logic [UADDR_W-1:0] upc_reg, upc_next;
    logic               illegal_reg, illegal_next;
    seq_t               seq;
    logic [UADDR_W-1:0] tgt;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_default
            assign default_tbl[gi] = default_word(gi);
        end
    endgenerate

`ifdef UCODE_LOAD_EN
    logic [MW-1:0] store_reg [DEPTH];

    // Writable store: reset restores the default program and drops a same-cycle write
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                store_reg[i] <= default_tbl[i];
            end
        end else if (ld_we) begin
            store_reg[ld_addr] <= ld_data;
        end
    end

    assign word = store_reg[upc_reg];
`else
    assign word = default_tbl[upc_reg];
`endif

    assign seq = seq_t'(word[MW-1 -: 2]);
    assign tgt = word[CW_W +: UADDR_W];
    assign cw  = word[CW_W-1:0];

    // Next micro-address: hold on stall, otherwise sequence or dispatch on op
    always_comb begin
        upc_next     = upc_reg;
        illegal_next = 1'b0;
        if (!stall) begin
            case (seq)
                SEQ_FETCH: upc_next = '0;
                SEQ_JUMP:  upc_next = tgt;
                SEQ_DISP1: begin
                    if (op == OP_LOAD || op == OP_STORE) upc_next = UADDR_W'(2);
                    else if (op == OP_RTYPE)             upc_next = UADDR_W'(6);
                    else if (op == OP_ITYPE)             upc_next = UADDR_W'(7);
                    else if (op == OP_BRANCH)            upc_next = UADDR_W'(9);
                    else begin
                        upc_next     = '0;
                        illegal_next = 1'b1;
                    end
                end
                SEQ_DISP2: begin
                    if (op == OP_LOAD)       upc_next = UADDR_W'(3);
                    else if (op == OP_STORE) upc_next = UADDR_W'(5);
                    else begin
                        upc_next     = '0;
                        illegal_next = 1'b1;
                    end
                end
                default: upc_next = '0;
            endcase
        end
    end

    // Micro-PC and illegal-pulse registers; reset wins over stall
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            upc_reg     <= '0;
            illegal_reg <= 1'b0;
        end else begin
            upc_reg     <= upc_next;
            illegal_reg <= illegal_next;
        end
    end

    assign upc     = upc_reg;
    assign illegal = illegal_reg;

endmodule
